painterengine_gpu_dma_reader: RTL and testbench
===============================================

# painterengine_gpu_dma_reader

AXI4 read-master stage that sits directly upstream of the GPU DMA writer's data input. It fetches a word-aligned 32-bit buffer from memory for one of four router channels and presents it as a valid/next stream on the channel lane that the writer consumes. Bursts are split at PARAM_MAX_BURST-beat address boundaries, and a local FIFO decouples AXI R traffic from consumer back-pressure.

## Interface
Parameters:
- PARAM_MAX_BURST, 16: maximum beats per AR burst; power of 2, range 2..256.
- PARAM_FIFO_DEPTH, 32: read FIFO depth in words; power of 2, at least PARAM_MAX_BURST.
- PARAM_TIMEOUT, 256: cycle limit for an AR or R stall before an error is raised.

Ports:
- i_wire_clock  in  1  clock.
- i_wire_resetn  in  1  asynchronous, active-low reset.
- i_wire_router  in  4  one-hot channel select, sampled in ROUTING.
- i_wire_address  in  128  per-channel byte address, lane n = [n*32+:32].
- i_wire_length  in  128  per-channel length in 32-bit words.
- o_wire_data  out  128  FIFO head on the selected lane; other lanes are 0.
- o_wire_data_valid  out  4  FIFO non-empty, on the selected bit only.
- i_wire_data_next  in  4  consumer accepts the head word.
- o_wire_done  out  1  state == DONE.
- o_wire_error  out  1  state[4].
- o_wire_error_type  out  3  state[2:0] while in an error state, else 0.
- AR channel, fixed values:
  - o_wire_M_AXI_ARID out 1 = 0; o_wire_M_AXI_ARSIZE out 3 = 3'b010; o_wire_M_AXI_ARBURST out 2 = 2'b01.
  - o_wire_M_AXI_ARLOCK out 1 = 0; o_wire_M_AXI_ARCACHE out 4 = 4'b0010; o_wire_M_AXI_ARPROT out 3 = 0; o_wire_M_AXI_ARQOS out 4 = 0.
- AR channel, driven:
  - o_wire_M_AXI_ARADDR out 32; o_wire_M_AXI_ARLEN out 8 = beats-1.
  - o_wire_M_AXI_ARVALID out 1; i_wire_M_AXI_ARREADY in 1.
- R channel:
  - i_wire_M_AXI_RID in 1, ignored; i_wire_M_AXI_RDATA in 32; i_wire_M_AXI_RRESP in 2; i_wire_M_AXI_RLAST in 1.
  - i_wire_M_AXI_RVALID in 1; o_wire_M_AXI_RREADY out 1.

## Operation
State encoding is 5 bits. States and transitions:
- ROUTING 0x01, entered on reset:
  - router 1, 2, 4 or 8 latches idx, address and length, then goes to PARAM_CHECK.
  - Any other router value goes to ERR_ROUTING 0x10.
- PARAM_CHECK 0x02:
  - address[1:0] != 0 goes to ERR_ALIGN 0x11.
  - length == 0 goes to ERR_LENGTH 0x12.
  - Otherwise goes to CALC.
- CALC 0x03:
  - waddr = address + offset*4.
  - beats = min(PARAM_MAX_BURST - waddr[2+:log2(PARAM_MAX_BURST)], length - offset).
  - Computation is 32-bit unsigned, 9-bit beat count; bursts therefore never cross a 4 KB boundary.
  - Stays in CALC while FIFO free space (DEPTH - count) < beats.
  - Otherwise loads ARADDR/ARLEN, sets ARVALID=1 and goes to ADDR.
- ADDR 0x04:
  - Holds ARVALID, ARADDR and ARLEN stable until ARREADY.
  - On ARVALID && ARREADY: ARVALID=0, beat counter = 0, timer = 0, go to DATA.
  - Timer exceeding PARAM_TIMEOUT goes to ERR_AR 0x13.
- DATA 0x05:
  - RREADY=1. Space was reserved in CALC, so the FIFO never overflows.
  - Each RVALID beat pushes RDATA and increments the beat counter.
  - RRESP > 2'b01 goes to ERR_RESP 0x14.
  - An RLAST/beat-count mismatch goes to ERR_RESP 0x14: RLAST on a beat other than the last, or no RLAST on the last beat.
  - On the last beat: offset += beats; next state is DRAIN if offset == length, else CALC.
  - The timer counts cycles with RVALID low; exceeding PARAM_TIMEOUT goes to ERR_RDATA 0x15.
- DRAIN 0x06: waits for FIFO empty, then goes to DONE.
- DONE 0x07 and all error states are sticky until reset. In these states: ARVALID=0, RREADY=0, data_valid=0.

FIFO behaviour:
- Pop occurs on data_valid[idx] && data_next[idx].
- Push and pop in the same cycle leave count unchanged.
- Consumer stalls are unbounded and never count toward a timeout.
- data_next on a non-selected bit is ignored.

## Timing
Reset values (asynchronous, effective immediately):
- State ROUTING; ARVALID=0, RREADY=0, ARADDR=0, ARLEN=0.
- o_wire_data=0, data_valid=0, done=0, error=0, error_type=0.
- FIFO empty; offset=0.

Latency and handshake rules:
- Minimum latency from reset release to first ARVALID is 3 cycles (ROUTING, PARAM_CHECK, CALC).
- A word pushed in cycle t is valid at the output in cycle t+1.
- Sustained throughput is 1 word/cycle when memory and consumer are both ready; the only gap is the CALC and ADDR turnaround of at least 2 cycles between bursts.
- RREADY is a registered function of state and is high for the whole DATA state.

## Test plan
- Channel 1 (router=2), address 0x1000_0000, length 40, memory always ready, consumer always ready:
  - ARs at 0x..00, 0x..40, 0x..80 with ARLEN 15, 15, 7.
  - 40 words appear in order on lane 1 and data_valid[1] only; done asserts after the last pop.
- Address 0x1000_0038, length 20:
  - First burst is 2 beats, then 16, then 2; no burst crosses a 64-byte boundary.
- Consumer holds data_next low for 500 cycles mid-transfer:
  - No AR is issued once FIFO free < beats; no timeout; all data is delivered intact afterwards.
- router=4'b0011 -> error=1, error_type=0; address 0x...2 -> error_type=1; length 0 -> error_type=2. ARVALID never asserts in any of these cases.
- RRESP=2'b10 on beat 5 -> ERR_RESP (error_type=4). RVALID withheld for 300 cycles -> ERR_RDATA (error_type=5).
- Reset asserted mid-DATA -> ARVALID, RREADY and data_valid go low the same cycle; after release, a new transfer completes correctly.

Source files
------------

// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master feeding the GPU DMA writer: fetches a word buffer for one router
// channel in boundary-aligned bursts and streams it through a local FIFO.
module painterengine_gpu_dma_reader #(
  parameter int PARAM_MAX_BURST  = 16,
  parameter int PARAM_FIFO_DEPTH = 32,
  parameter int PARAM_TIMEOUT    = 256
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_resetn,
  input  logic [3:0]   i_wire_router,
  input  logic [127:0] i_wire_address,
  input  logic [127:0] i_wire_length,
  output logic [127:0] o_wire_data,
  output logic [3:0]   o_wire_data_valid,
  input  logic [3:0]   i_wire_data_next,
  output logic         o_wire_done,
  output logic         o_wire_error,
  output logic [2:0]   o_wire_error_type,
  output logic         o_wire_M_AXI_ARID,
  output logic [31:0]  o_wire_M_AXI_ARADDR,
  output logic [7:0]   o_wire_M_AXI_ARLEN,
  output logic [2:0]   o_wire_M_AXI_ARSIZE,
  output logic [1:0]   o_wire_M_AXI_ARBURST,
  output logic         o_wire_M_AXI_ARLOCK,
  output logic [3:0]   o_wire_M_AXI_ARCACHE,
  output logic [2:0]   o_wire_M_AXI_ARPROT,
  output logic [3:0]   o_wire_M_AXI_ARQOS,
  output logic         o_wire_M_AXI_ARVALID,
  input  logic         i_wire_M_AXI_ARREADY,
  input  logic         i_wire_M_AXI_RID,
  input  logic [31:0]  i_wire_M_AXI_RDATA,
  input  logic [1:0]   i_wire_M_AXI_RRESP,
  input  logic         i_wire_M_AXI_RLAST,
  input  logic         i_wire_M_AXI_RVALID,
  output logic         o_wire_M_AXI_RREADY
);

  localparam int BURST_W = $clog2(PARAM_MAX_BURST);
  localparam int PTR_W   = $clog2(PARAM_FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMR_W   = $clog2(PARAM_TIMEOUT + 1) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(PARAM_FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(PARAM_TIMEOUT);

  typedef enum logic [4:0] {
    ST_ROUTING     = 5'h01,
    ST_PARAM_CHECK = 5'h02,
    ST_CALC        = 5'h03,
    ST_ADDR        = 5'h04,
    ST_DATA        = 5'h05,
    ST_DRAIN       = 5'h06,
    ST_DONE        = 5'h07,
    ST_ERR_ROUTING = 5'h10,
    ST_ERR_ALIGN   = 5'h11,
    ST_ERR_LENGTH  = 5'h12,
    ST_ERR_AR      = 5'h13,
    ST_ERR_RESP    = 5'h14,
    ST_ERR_RDATA   = 5'h15
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] lane_sel(input logic [127:0] bus, input logic [1:0] idx);
    return bus[{idx, 5'b00000} +: 32];
  endfunction

  state_t              state_r, state_s;
  logic [3:0]          router_r, router_s;
  logic [31:0]         addr_r, addr_s;
  logic [31:0]         len_r, len_s;
  logic [31:0]         offset_r, offset_s;
  logic [31:0]         araddr_r, araddr_s;
  logic [7:0]          arlen_r, arlen_s;
  logic                arvalid_r, arvalid_s;
  logic                rready_r, rready_s;
  logic [7:0]          beat_r, beat_s;
  logic [TMR_W-1:0]    timer_r, timer_s;
  logic                push_s, pop_s;

  logic [31:0]         fifo_mem_r [PARAM_FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    count_r;

  logic [31:0]         waddr_s, remain_s, offset_sum_s;
  logic [8:0]          rem_s, beats_s;
  logic [CNT_W-1:0]    free_s;
  logic                last_beat_s, sticky_s, unused_ok_s;
  logic [3:0]          data_valid_s;
  logic [31:0]         head_s;

  // Burst sizing: never run past the next PARAM_MAX_BURST-word boundary nor the buffer end
  assign waddr_s      = addr_r + {offset_r[29:0], 2'b00};
  assign rem_s        = 9'(PARAM_MAX_BURST) - 9'(waddr_s[2 +: BURST_W]);
  assign remain_s     = len_r - offset_r;
  assign beats_s      = (remain_s < 32'(rem_s)) ? remain_s[8:0] : rem_s;
  assign free_s       = CNT_DEPTH - count_r;
  assign last_beat_s  = (beat_r == arlen_r);
  assign offset_sum_s = offset_r + 32'(arlen_r) + 32'd1;
  assign sticky_s     = (state_r == ST_DONE) || state_r[4];
  assign unused_ok_s  = i_wire_M_AXI_RID;

  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign data_valid_s = ((count_r != {CNT_W{1'b0}}) && !sticky_s) ? router_r : 4'b0000;
  assign pop_s        = |(data_valid_s & i_wire_data_next);

  // Next-state and datapath update for the transfer sequencer
  always_comb begin
    state_s   = state_r;
    router_s  = router_r;
    addr_s    = addr_r;
    len_s     = len_r;
    offset_s  = offset_r;
    araddr_s  = araddr_r;
    arlen_s   = arlen_r;
    arvalid_s = arvalid_r;
    rready_s  = rready_r;
    beat_s    = beat_r;
    timer_s   = timer_r;
    push_s    = 1'b0;
    case (state_r)
      ST_ROUTING: begin
        case (i_wire_router)
          4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
            router_s = i_wire_router;
            addr_s   = lane_sel(i_wire_address, onehot_to_idx(i_wire_router));
            len_s    = lane_sel(i_wire_length, onehot_to_idx(i_wire_router));
            offset_s = 32'd0;
            state_s  = ST_PARAM_CHECK;
          end
          default: state_s = ST_ERR_ROUTING;
        endcase
      end
      ST_PARAM_CHECK: begin
        if (addr_r[1:0] != 2'b00) begin
          state_s = ST_ERR_ALIGN;
        end else if (len_r == 32'd0) begin
          state_s = ST_ERR_LENGTH;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_CALC: begin
        // Reserve FIFO room for the whole burst before asking for it
        if (32'(free_s) < 32'(beats_s)) begin
          state_s = ST_CALC;
        end else begin
          araddr_s  = waddr_s;
          arlen_s   = 8'(beats_s - 9'd1);
          arvalid_s = 1'b1;
          timer_s   = {TMR_W{1'b0}};
          state_s   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (i_wire_M_AXI_ARREADY) begin
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
          beat_s    = 8'd0;
          timer_s   = {TMR_W{1'b0}};
          state_s   = ST_DATA;
        end else if (timer_r >= TMR_LIMIT) begin
          arvalid_s = 1'b0;
          state_s   = ST_ERR_AR;
        end else begin
          timer_s = timer_r + TMR_ONE;
        end
      end
      ST_DATA: begin
        if (i_wire_M_AXI_RVALID) begin
          timer_s = {TMR_W{1'b0}};
          if ((i_wire_M_AXI_RRESP > 2'b01) || (i_wire_M_AXI_RLAST != last_beat_s)) begin
            rready_s = 1'b0;
            state_s  = ST_ERR_RESP;
          end else if (last_beat_s) begin
            push_s   = 1'b1;
            offset_s = offset_sum_s;
            rready_s = 1'b0;
            state_s  = (offset_sum_s == len_r) ? ST_DRAIN : ST_CALC;
          end else begin
            push_s = 1'b1;
            beat_s = beat_r + 8'd1;
          end
        end else if (timer_r >= TMR_LIMIT) begin
          rready_s = 1'b0;
          state_s  = ST_ERR_RDATA;
        end else begin
          timer_s = timer_r + TMR_ONE;
        end
      end
      ST_DRAIN: begin
        if (count_r == {CNT_W{1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE, ST_ERR_ROUTING, ST_ERR_ALIGN, ST_ERR_LENGTH,
      ST_ERR_AR, ST_ERR_RESP, ST_ERR_RDATA: begin
        arvalid_s = 1'b0;
        rready_s  = 1'b0;
        state_s   = state_r;
      end
      default: begin
        // Corrupted state encoding lands in a reported, sticky error
        arvalid_s = 1'b0;
        rready_s  = 1'b0;
        state_s   = ST_ERR_ROUTING;
      end
    endcase
  end

  // Sequencer state and AXI request registers
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_r   <= ST_ROUTING;
      router_r  <= 4'b0000;
      addr_r    <= 32'd0;
      len_r     <= 32'd0;
      offset_r  <= 32'd0;
      araddr_r  <= 32'd0;
      arlen_r   <= 8'd0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      beat_r    <= 8'd0;
      timer_r   <= {TMR_W{1'b0}};
    end else begin
      state_r   <= state_s;
      router_r  <= router_s;
      addr_r    <= addr_s;
      len_r     <= len_s;
      offset_r  <= offset_s;
      araddr_r  <= araddr_s;
      arlen_r   <= arlen_s;
      arvalid_r <= arvalid_s;
      rready_r  <= rready_s;
      beat_r    <= beat_s;
      timer_r   <= timer_s;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge i_wire_clock) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= i_wire_M_AXI_RDATA;
    end
  end

  // Place the FIFO head on the selected lane only
  always_comb begin
    o_wire_data = 128'd0;
    for (int n = 0; n < 4; n++) begin
      if (data_valid_s[n]) begin
        o_wire_data[n*32 +: 32] = head_s;
      end else begin
        o_wire_data[n*32 +: 32] = 32'd0;
      end
    end
  end

  assign o_wire_data_valid    = data_valid_s;
  assign o_wire_done          = (state_r == ST_DONE);
  assign o_wire_error         = state_r[4];
  assign o_wire_error_type    = state_r[4] ? state_r[2:0] : 3'b000;
  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = araddr_r;
  assign o_wire_M_AXI_ARLEN   = arlen_r;
  assign o_wire_M_AXI_ARSIZE  = 3'b010;
  assign o_wire_M_AXI_ARBURST = 2'b01;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = 4'b0010;
  assign o_wire_M_AXI_ARPROT  = 3'b000;
  assign o_wire_M_AXI_ARQOS   = 4'b0000;
  assign o_wire_M_AXI_ARVALID = arvalid_r;
  assign o_wire_M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Directed bench for painterengine_gpu_dma_reader with a behavioural AXI read slave
// and consumer; expected bursts and error codes are hand-computed.
module tb_painterengine_gpu_dma_reader;

  logic         clk;
  logic         resetn;
  logic [3:0]   router;
  logic [127:0] address, length, data;
  logic [3:0]   dv, next;
  logic         done, error;
  logic [2:0]   etype;
  logic         arid, arlock, arvalid, arready;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst, rresp;
  logic [3:0]   arcache, arqos;
  logic         rid, rlast, rvalid, rready;
  logic [31:0]  rdata;

  painterengine_gpu_dma_reader dut (
    .i_wire_clock(clk), .i_wire_resetn(resetn), .i_wire_router(router),
    .i_wire_address(address), .i_wire_length(length),
    .o_wire_data(data), .o_wire_data_valid(dv), .i_wire_data_next(next),
    .o_wire_done(done), .o_wire_error(error), .o_wire_error_type(etype),
    .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr), .o_wire_M_AXI_ARLEN(arlen),
    .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst), .o_wire_M_AXI_ARLOCK(arlock),
    .o_wire_M_AXI_ARCACHE(arcache), .o_wire_M_AXI_ARPROT(arprot), .o_wire_M_AXI_ARQOS(arqos),
    .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
    .i_wire_M_AXI_RID(rid), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
    .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid), .o_wire_M_AXI_RREADY(rready)
  );

  int          total_cnt, bad_cnt;
  logic [31:0] got_q[$];
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [31:0] bq_addr[$];
  int          bq_len[$];
  int          beat, resp_err_beat, lane_bad, arv_cycles;
  bit          r_en, next_en;
  logic [3:0]  exp_mask;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // AXI read slave, consumer and output monitor
  initial begin
    bit          ar_fire, r_fire;
    logic [31:0] fa;
    logic [7:0]  fl;
    rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rid = 1'b0;
    arready = 1'b1; next = 4'b0000; beat = 0;
    forever begin
      @(negedge clk);
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      fa = araddr;
      fl = arlen;
      if (arvalid) arv_cycles++;
      if ((dv & ~exp_mask) != 4'b0000) lane_bad++;
      for (int n = 0; n < 4; n++) begin
        if (!dv[n] && data[n*32 +: 32] != 32'd0) lane_bad++;
        if (dv[n] && next[n]) got_q.push_back(data[n*32 +: 32]);
      end
      if (ar_fire) begin
        ar_addr_q.push_back(fa);
        ar_len_q.push_back(fl);
      end
      @(posedge clk);
      #1;
      if (!resetn) begin
        bq_addr.delete();
        bq_len.delete();
        beat = 0;
      end else begin
        if (r_fire && bq_addr.size() > 0) begin
          beat++;
          if (beat > bq_len[0]) begin
            void'(bq_addr.pop_front());
            void'(bq_len.pop_front());
            beat = 0;
          end
        end
        if (ar_fire) begin
          bq_addr.push_back(fa);
          bq_len.push_back(int'(fl));
        end
      end
      next = next_en ? 4'b1111 : 4'b0000;
      if (resetn && r_en && bq_addr.size() > 0) begin
        rvalid = 1'b1;
        rdata  = mem_word(bq_addr[0] + 32'(beat * 4));
        rlast  = (beat == bq_len[0]);
        rresp  = (beat == resp_err_beat) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
      end
    end
  end

  task automatic start(input logic [3:0] rt, input logic [31:0] a, input logic [31:0] l);
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got_q.delete(); ar_addr_q.delete(); ar_len_q.delete();
    lane_bad = 0; arv_cycles = 0;
    router = rt; exp_mask = rt;
    address = {4{32'h0BAD_0001}};
    length  = {4{32'd7}};
    for (int n = 0; n < 4; n++) begin
      if (rt[n]) begin
        address[n*32 +: 32] = a;
        length[n*32 +: 32]  = l;
      end
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || error) break;
    end
  endtask

  task automatic check_words(input string tag, input logic [31:0] base, input int n);
    check_eq({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      check_eq($sformatf("%s_w%0d", tag, i), got_q[i], mem_word(base + 32'(i * 4)));
  endtask

  task automatic check_ar(input string tag, input int k, input logic [31:0] a, input logic [7:0] l);
    if (k < ar_addr_q.size()) begin
      check_eq({tag, "_addr"}, ar_addr_q[k], a);
      check_eq({tag, "_len"}, ar_len_q[k], l);
    end else begin
      check_eq({tag, "_missing"}, ar_addr_q.size(), k + 1);
    end
  endtask

  typedef struct { logic [3:0] rt; logic [31:0] a; logic [31:0] l; logic [2:0] et; } err_vec_t;
  err_vec_t err_vecs[3];

  initial begin
    int n;
    total_cnt = 0; bad_cnt = 0;
    r_en = 1'b1; next_en = 1'b1; resp_err_beat = -1; exp_mask = 4'b0000;
    lane_bad = 0; arv_cycles = 0;
    router = 4'b0000; address = 128'd0; length = 128'd0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_arvalid", arvalid, 1'b0);
    check_eq("rst_rready", rready, 1'b0);
    check_eq("rst_araddr", araddr, 32'd0);
    check_eq("rst_arlen", arlen, 8'd0);
    check_eq("rst_data", data != 128'd0, 1'b0);
    check_eq("rst_valid", dv, 4'b0000);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_etype", etype, 3'd0);
    check_eq("arsize", arsize, 3'b010);
    check_eq("arburst", arburst, 2'b01);
    check_eq("arcache", arcache, 4'b0010);

    // Channel 1, aligned, 40 words
    start(4'b0010, 32'h1000_0000, 32'd40);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (arvalid) break;
    end
    check_eq("ar_latency", n, 3);
    wait_end(2000);
    check_eq("t1_done", done, 1'b1);
    check_eq("t1_error", error, 1'b0);
    check_eq("t1_ar_count", ar_addr_q.size(), 3);
    check_ar("t1_ar0", 0, 32'h1000_0000, 8'd15);
    check_ar("t1_ar1", 1, 32'h1000_0040, 8'd15);
    check_ar("t1_ar2", 2, 32'h1000_0080, 8'd7);
    check_words("t1", 32'h1000_0000, 40);
    check_eq("t1_lane", lane_bad, 0);
    check_eq("t1_valid_done", dv, 4'b0000);

    // Unaligned start splits at 64-byte boundaries
    start(4'b0001, 32'h1000_0038, 32'd20);
    wait_end(2000);
    check_eq("t2_done", done, 1'b1);
    check_eq("t2_ar_count", ar_addr_q.size(), 3);
    check_ar("t2_ar0", 0, 32'h1000_0038, 8'd1);
    check_ar("t2_ar1", 1, 32'h1000_0040, 8'd15);
    check_ar("t2_ar2", 2, 32'h1000_0080, 8'd1);
    check_words("t2", 32'h1000_0038, 20);
    check_eq("t2_lane", lane_bad, 0);

    // Consumer stall: FIFO fills after two bursts, no further AR, no timeout
    next_en = 1'b0;
    start(4'b1000, 32'h2000_0000, 32'd64);
    repeat (500) @(negedge clk);
    check_eq("t3_stall_ar_count", ar_addr_q.size(), 2);
    check_eq("t3_stall_error", error, 1'b0);
    check_eq("t3_stall_valid", dv, 4'b1000);
    check_eq("t3_stall_arvalid", arvalid, 1'b0);
    next_en = 1'b1;
    wait_end(3000);
    check_eq("t3_done", done, 1'b1);
    check_eq("t3_ar_count", ar_addr_q.size(), 4);
    check_ar("t3_ar2", 2, 32'h2000_0080, 8'd15);
    check_ar("t3_ar3", 3, 32'h2000_00C0, 8'd15);
    check_words("t3", 32'h2000_0000, 64);
    check_eq("t3_lane", lane_bad, 0);

    // Parameter errors
    err_vecs[0] = '{4'b0011, 32'h1000_0000, 32'd4, 3'd0};
    err_vecs[1] = '{4'b0001, 32'h1000_0002, 32'd4, 3'd1};
    err_vecs[2] = '{4'b0001, 32'h1000_0000, 32'd0, 3'd2};
    for (int k = 0; k < 3; k++) begin
      start(err_vecs[k].rt, err_vecs[k].a, err_vecs[k].l);
      repeat (10) @(negedge clk);
      check_eq($sformatf("perr%0d_error", k), error, 1'b1);
      check_eq($sformatf("perr%0d_type", k), etype, err_vecs[k].et);
      check_eq($sformatf("perr%0d_done", k), done, 1'b0);
      check_eq($sformatf("perr%0d_arvalid", k), arv_cycles, 0);
    end

    // Error response on beat 5
    resp_err_beat = 5;
    start(4'b0001, 32'h3000_0000, 32'd16);
    wait_end(200);
    check_eq("resp_error", error, 1'b1);
    check_eq("resp_type", etype, 3'd4);
    check_eq("resp_valid", dv, 4'b0000);
    check_words("resp", 32'h3000_0000, 5);
    resp_err_beat = -1;

    // RVALID withheld: read-data timeout
    r_en = 1'b0;
    start(4'b0001, 32'h3000_0100, 32'd4);
    repeat (100) @(negedge clk);
    check_eq("rto_early_error", error, 1'b0);
    check_eq("rto_rready", rready, 1'b1);
    repeat (300) @(negedge clk);
    check_eq("rto_error", error, 1'b1);
    check_eq("rto_type", etype, 3'd5);
    check_eq("rto_rready_off", rready, 1'b0);
    r_en = 1'b1;

    // Reset mid-DATA, then a clean transfer
    start(4'b0100, 32'h4000_0000, 32'd40);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (got_q.size() >= 3) break;
    end
    check_eq("mid_progress", got_q.size() >= 3, 1'b1);
    check_eq("mid_rready_before", rready, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check_eq("mid_arvalid", arvalid, 1'b0);
    check_eq("mid_rready", rready, 1'b0);
    check_eq("mid_valid", dv, 4'b0000);
    start(4'b0100, 32'h4000_0100, 32'd8);
    wait_end(500);
    check_eq("post_done", done, 1'b1);
    check_eq("post_ar_count", ar_addr_q.size(), 1);
    check_ar("post_ar0", 0, 32'h4000_0100, 8'd7);
    check_words("post", 32'h4000_0100, 8);
    check_eq("post_lane", lane_bad, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
